// File: rtl/mcb_port_responder_pkg.sv
// ----------------------------------------------------------------------------
// mcb_port_responder_pkg
//  Shared definitions for the BRAM-backed MCB port responder: command
//  instruction encodings, field widths, FIFO entry layouts and FSM states.
//  Also intended for the port0/port1 controllers that issue these commands.
// ----------------------------------------------------------------------------
package mcb_port_responder_pkg;

   // MCB command instruction encodings
   localparam logic [2:0] MCB_WR    = 3'b000;
   localparam logic [2:0] MCB_RD    = 3'b001;
   localparam logic [2:0] MCB_WR_AP = 3'b010;
   localparam logic [2:0] MCB_RD_AP = 3'b011;
   localparam logic [2:0] MCB_RFSH  = 3'b100;

   localparam int BL_W        = 6;   // burst length minus one
   localparam int CNT_W       = 7;   // FIFO occupancy, 0..64
   localparam int BYTE_ADDR_W = 30;
   localparam int DATA_W      = 32;
   localparam int MASK_W      = 4;

   // Command FIFO entry (39 bits)
   typedef struct packed {
      logic [2:0]             instr;
      logic [BL_W-1:0]        bl;
      logic [BYTE_ADDR_W-1:0] byte_addr;
   } cmd_t;

   // Write FIFO entry (36 bits)
   typedef struct packed {
      logic [MASK_W-1:0] mask;
      logic [DATA_W-1:0] data;
   } wr_word_t;

   typedef enum logic [2:0] {
      ST_CALIB,
      ST_IDLE,
      ST_WR_WAIT,
      ST_WRITE,
      ST_RD_WAIT,
      ST_READ,
      ST_RFSH
   } state_e;

   // Auto-precharge variants behave exactly like the plain ones here.
   function automatic logic is_wr(input logic [2:0] instr);
      return (instr == MCB_WR) || (instr == MCB_WR_AP);
   endfunction

   function automatic logic is_rd(input logic [2:0] instr);
      return (instr == MCB_RD) || (instr == MCB_RD_AP);
   endfunction

endpackage

// File: rtl/mcb_port_responder_sync_fifo.sv
// ----------------------------------------------------------------------------
// mcb_port_responder_sync_fifo
//  Single-clock first-word-fall-through FIFO with occupancy count.
//  DEPTH must be a power of two, 2..64. Push when full and pop when empty are
//  ignored; data_o reads as zero while empty.
// Ports
//  clk, reset      clock, synchronous active-high reset (flushes, keeps data)
//  push_i, data_i  write side
//  pop_i, data_o   read side (data_o is the head entry)
//  full_o, empty_o occupancy flags
//  count_o         number of stored entries
// ----------------------------------------------------------------------------
module mcb_port_responder_sync_fifo
   import mcb_port_responder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count alone define validity,
   // and a resettable array would not map onto RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/mcb_port_responder.sv
// ----------------------------------------------------------------------------
// mcb_port_responder
//  Target side of one MCB-style user port (command / write FIFO / read FIFO)
//  backed by on-chip block RAM. Stands in for a DDR2 port so the port
//  controllers can run without external memory.
// Ports
//  clk, reset                     clock, synchronous active-high reset
//  calib_done                     high once CALIB_CYCLES have passed after reset
//  cmd_en/instr/bl/byte_addr      command push; cmd_full = command FIFO full
//  wr_en/wr_data/wr_mask          write-data push (mask bit 1 = byte not written)
//  wr_full/wr_empty/wr_count      write FIFO status
//  rd_en/rd_data                  read FIFO pop, FWFT head word
//  rd_full/rd_empty/rd_count      read FIFO status
//  wr_error                       sticky: wr_en while wr_full
//  rd_error                       sticky: rd_en while rd_empty, or illegal instruction
// ----------------------------------------------------------------------------
module mcb_port_responder
   import mcb_port_responder_pkg::*;
#(
   parameter int ADDR_BITS    = 12,
   parameter int FIFO_DEPTH   = 64,
   parameter int CMD_DEPTH    = 4,
   parameter int CALIB_CYCLES = 16,
   parameter int RFSH_CYCLES  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   calib_done,
   input  logic                   cmd_en,
   input  logic [2:0]             cmd_instr,
   input  logic [BL_W-1:0]        cmd_bl,
   input  logic [BYTE_ADDR_W-1:0] cmd_byte_addr,
   output logic                   cmd_full,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic [MASK_W-1:0]      wr_mask,
   output logic                   wr_full,
   output logic                   wr_empty,
   output logic [CNT_W-1:0]       wr_count,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_full,
   output logic                   rd_empty,
   output logic [CNT_W-1:0]       rd_count,
   output logic                   wr_error,
   output logic                   rd_error
);

   state_e                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;     // calib / beat / refresh counter
   cmd_t                  cmd_q, cmd_d;     // command being executed
   cmd_t                  cmd_in, cmd_head;
   wr_word_t              wr_in, wr_head;
   logic                  cmd_empty, cmd_pop, cmd_illegal;
   logic                  wr_issue, rd_issue, wr_room, rd_room, last_beat;
   logic [CNT_W:0]        rd_avail;
   logic [ADDR_BITS-1:0]  mem_addr;
   logic [DATA_W-1:0]     bram_q [2**ADDR_BITS];
   logic [DATA_W-1:0]     rd_word_q;
   logic                  rd_vld_q;
   logic                  wr_err_q, rd_err_q;
   logic [CNT_W-1:0]      cmd_count_unused;
   logic                  unused_addr_bits;

   assign cmd_in = '{instr: cmd_instr, bl: cmd_bl, byte_addr: cmd_byte_addr};
   assign wr_in  = '{mask: wr_mask, data: wr_data};

   mcb_port_responder_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk(clk), .reset(reset), .push_i(cmd_en), .pop_i(cmd_pop), .data_i(cmd_in),
      .data_o(cmd_head), .full_o(cmd_full), .empty_o(cmd_empty), .count_o(cmd_count_unused)
   );

   mcb_port_responder_sync_fifo #(.WIDTH($bits(wr_word_t)), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .clk(clk), .reset(reset), .push_i(wr_en), .pop_i(wr_issue), .data_i(wr_in),
      .data_o(wr_head), .full_o(wr_full), .empty_o(wr_empty), .count_o(wr_count)
   );

   mcb_port_responder_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
      .clk(clk), .reset(reset), .push_i(rd_vld_q), .pop_i(rd_en), .data_i(rd_word_q),
      .data_o(rd_data), .full_o(rd_full), .empty_o(rd_empty), .count_o(rd_count)
   );

   // Only the word-address bits of the byte address reach the BRAM.
   assign unused_addr_bits = ^{cmd_q.byte_addr[BYTE_ADDR_W-1:ADDR_BITS+2], cmd_q.byte_addr[1:0]};

   // Word address wraps modulo the BRAM size by truncation.
   assign mem_addr  = cmd_q.byte_addr[ADDR_BITS+1:2] + ADDR_BITS'(cnt_q[BL_W-1:0]);
   assign last_beat = (cnt_q[BL_W-1:0] == cmd_q.bl);

   // A write burst starts only once all its words are queued, so WRITE never starves.
   assign wr_room  = (wr_count >= CNT_W'(cmd_q.bl) + CNT_W'(1));
   // A read burst reserves its whole footprint in the read FIFO up front; the word
   // fetched last cycle is not yet counted by the FIFO and must be included.
   assign rd_avail = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, rd_count} - (CNT_W+1)'(rd_vld_q);
   assign rd_room  = (rd_avail >= (CNT_W+1)'(cmd_q.bl) + (CNT_W+1)'(1));

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CALIB;
         cnt_q   <= '0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
      end
   end

   // FSM: next state. The first beat of a burst issues from the WAIT state in the
   // same cycle its condition holds, keeping read latency at four cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      case (state_q)
         ST_CALIB: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'(CALIB_CYCLES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            if (!cmd_empty) begin
               cmd_d = cmd_head;
               cnt_d = '0;
               if (is_wr(cmd_head.instr))            state_d = ST_WR_WAIT;
               else if (is_rd(cmd_head.instr))       state_d = ST_RD_WAIT;
               else if (cmd_head.instr == MCB_RFSH)  state_d = ST_RFSH;
            end
         end
         ST_WR_WAIT, ST_RD_WAIT: begin
            if ((state_q == ST_WR_WAIT) ? wr_room : rd_room) begin
               cnt_d   = 16'd1;
               state_d = (cmd_q.bl == '0) ? ST_IDLE
                       : ((state_q == ST_WR_WAIT) ? ST_WRITE : ST_READ);
            end
         end
         ST_WRITE, ST_READ: begin
            cnt_d = cnt_q + 16'd1;
            if (last_beat) state_d = ST_IDLE;
         end
         ST_RFSH: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'(RFSH_CYCLES - 1)) state_d = ST_IDLE;
         end
         default: state_d = ST_CALIB;
      endcase
   end

   // FSM: outputs
   always_comb begin
      calib_done  = (state_q != ST_CALIB);
      cmd_pop     = (state_q == ST_IDLE) && !cmd_empty;
      cmd_illegal = cmd_pop && !is_wr(cmd_head.instr) && !is_rd(cmd_head.instr)
                    && (cmd_head.instr != MCB_RFSH);
      wr_issue    = ((state_q == ST_WR_WAIT) && wr_room) || (state_q == ST_WRITE);
      rd_issue    = ((state_q == ST_RD_WAIT) && rd_room) || (state_q == ST_READ);
   end

   // Backing store with per-byte write enables; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_issue) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (!wr_head.mask[b]) bram_q[mem_addr][8*b +: 8] <= wr_head.data[8*b +: 8];
         end
      end
      if (rd_issue) rd_word_q <= bram_q[mem_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_vld_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         rd_vld_q <= rd_issue;
         wr_err_q <= wr_err_q | (wr_en & wr_full);
         rd_err_q <= rd_err_q | (rd_en & rd_empty) | cmd_illegal;
      end
   end

   assign wr_error = wr_err_q;
   assign rd_error = rd_err_q;

endmodule

// File: tb/tb_mcb_port_responder.sv
// ----------------------------------------------------------------------------
// tb_mcb_port_responder
//  Directed bench for mcb_port_responder with default parameters. Inputs are
//  driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mcb_port_responder;
   import mcb_port_responder_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        calib_done;
   logic        cmd_en = 1'b0;
   logic [2:0]  cmd_instr = '0;
   logic [5:0]  cmd_bl = '0;
   logic [29:0] cmd_byte_addr = '0;
   logic        cmd_full;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_mask = '0;
   logic        wr_full, wr_empty;
   logic [6:0]  wr_count;
   logic        rd_en = 1'b0;
   logic [31:0] rd_data;
   logic        rd_full, rd_empty;
   logic [6:0]  rd_count;
   logic        wr_error, rd_error;

   int n_vec = 0;
   int n_err = 0;

   mcb_port_responder dut (
      .clk(clk), .reset(reset), .calib_done(calib_done),
      .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
      .cmd_full(cmd_full),
      .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
      .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
      .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty), .rd_count(rd_count),
      .wr_error(wr_error), .rd_error(rd_error)
   );

   always #5 clk = ~clk;

   // ---- stimulus helpers (all start and end on a falling edge) ----
   task automatic apply_reset();
      reset = 1'b1; cmd_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] d, input logic [3:0] m);
      wr_en = 1'b1; wr_data = d; wr_mask = m;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
      for (int t = 0; t < 100 && cmd_full; t++) @(negedge clk);
      if (cmd_full) begin
         n_vec++; n_err++;
         $display("FAIL cmd_full_timeout: cmd_full=%b, required 0", cmd_full);
      end
      cmd_en = 1'b1; cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = addr;
      @(negedge clk);
      cmd_en = 1'b0;
   endtask

   task automatic pop_word(output logic [31:0] d);
      d = rd_data;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic wait_rd_count(input logic [6:0] target, input string name);
      for (int i = 0; i < 300 && rd_count !== target; i++) @(negedge clk);
      n_vec++;
      if (rd_count !== target) begin
         n_err++;
         $display("FAIL %s: rd_count=%0d, required %0d", name, rd_count, target);
      end
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      apply_reset();
      n_vec++; if (calib_done !== 1'b0) begin n_err++; $display("FAIL rst_calib_done: got %b want 0", calib_done); end
      n_vec++; if (cmd_full !== 1'b0)   begin n_err++; $display("FAIL rst_cmd_full: got %b want 0", cmd_full); end
      n_vec++; if ({wr_full, wr_empty} !== 2'b01) begin n_err++; $display("FAIL rst_wr_flags: got %b want 01", {wr_full, wr_empty}); end
      n_vec++; if (wr_count !== 7'd0)   begin n_err++; $display("FAIL rst_wr_count: got %0d want 0", wr_count); end
      n_vec++; if ({rd_full, rd_empty} !== 2'b01) begin n_err++; $display("FAIL rst_rd_flags: got %b want 01", {rd_full, rd_empty}); end
      n_vec++; if (rd_count !== 7'd0)   begin n_err++; $display("FAIL rst_rd_count: got %0d want 0", rd_count); end
      n_vec++; if (rd_data !== 32'h0)   begin n_err++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
      n_vec++; if ({wr_error, rd_error} !== 2'b00) begin n_err++; $display("FAIL rst_errors: got %b want 00", {wr_error, rd_error}); end
      // calib_done rises on the 16th rising edge after reset is released
      repeat (15) @(negedge clk);
      n_vec++; if (calib_done !== 1'b0) begin n_err++; $display("FAIL calib_early: got %b want 0 after 15 cycles", calib_done); end
      @(negedge clk);
      n_vec++; if (calib_done !== 1'b1) begin n_err++; $display("FAIL calib_rise: got %b want 1 after 16 cycles", calib_done); end
   endtask

   task automatic test_write_read();
      logic [31:0] d;
      for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), 4'b0000);
      n_vec++; if (wr_count !== 7'd4) begin n_err++; $display("FAIL wr_count_4: got %0d want 4", wr_count); end
      send_cmd(MCB_WR, 6'd3, 30'h100);
      send_cmd(MCB_RD_AP, 6'd3, 30'h100);
      wait_rd_count(7'd4, "wrrd_rd_count");
      n_vec++; if (wr_empty !== 1'b1) begin n_err++; $display("FAIL wrrd_wr_drained: wr_empty=%b want 1", wr_empty); end
      for (int i = 0; i < 4; i++) begin
         pop_word(d);
         n_vec++; if (d !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL wrrd_data%0d: got %h want %h", i, d, 32'hA0 + 32'(i)); end
      end
      n_vec++; if (rd_empty !== 1'b1) begin n_err++; $display("FAIL wrrd_rd_empty: got %b want 1", rd_empty); end
   endtask

   task automatic test_latency();
      logic [31:0] d;
      // byte address 0x103 hits word 0x40 (low two bits ignored), which holds A0
      cmd_en = 1'b1; cmd_instr = MCB_RD; cmd_bl = 6'd0; cmd_byte_addr = 30'h103;
      @(negedge clk);              // edge N: command pushed
      cmd_en = 1'b0;
      repeat (2) @(negedge clk);   // edges N+1 (decode), N+2 (BRAM read)
      n_vec++; if (rd_empty !== 1'b1) begin n_err++; $display("FAIL lat_early: rd_empty=%b want 1", rd_empty); end
      @(negedge clk);              // edge N+3: read FIFO written
      n_vec++; if (rd_empty !== 1'b0) begin n_err++; $display("FAIL lat_ready: rd_empty=%b want 0", rd_empty); end
      n_vec++; if (rd_data !== 32'hA0) begin n_err++; $display("FAIL lat_data: got %h want 000000a0", rd_data); end
      pop_word(d);
   endtask

   task automatic test_mask();
      logic [31:0] d;
      push_word(32'hFFFF_FFFF, 4'b0000);
      send_cmd(MCB_WR, 6'd0, 30'h200);
      push_word(32'h0000_0000, 4'b1010);   // bytes 1 and 3 keep 0xFF
      send_cmd(MCB_WR_AP, 6'd0, 30'h200);
      send_cmd(MCB_RD, 6'd0, 30'h200);
      push_word(32'h1234_5678, 4'b0001);   // byte 0 keeps 0x00
      send_cmd(MCB_WR, 6'd0, 30'h200);
      send_cmd(MCB_RD, 6'd0, 30'h200);
      wait_rd_count(7'd2, "mask_rd_count");
      pop_word(d);
      n_vec++; if (d !== 32'hFF00_FF00) begin n_err++; $display("FAIL mask_1010: got %h want ff00ff00", d); end
      pop_word(d);
      n_vec++; if (d !== 32'h1234_5600) begin n_err++; $display("FAIL mask_0001: got %h want 12345600", d); end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      push_word(32'h1111_1111, 4'b0000);
      push_word(32'h2222_2222, 4'b0000);
      send_cmd(MCB_WR, 6'd1, 30'h3FFC);    // word 4095, then wraps to word 0
      send_cmd(MCB_RD, 6'd1, 30'h3FFC);
      send_cmd(MCB_RD, 6'd0, 30'h0000);
      wait_rd_count(7'd3, "wrap_rd_count");
      pop_word(d);
      n_vec++; if (d !== 32'h1111_1111) begin n_err++; $display("FAIL wrap_top: got %h want 11111111", d); end
      pop_word(d);
      n_vec++; if (d !== 32'h2222_2222) begin n_err++; $display("FAIL wrap_beat1: got %h want 22222222", d); end
      pop_word(d);
      n_vec++; if (d !== 32'h2222_2222) begin n_err++; $display("FAIL wrap_word0: got %h want 22222222", d); end
   endtask

   task automatic test_refresh();
      logic [31:0] d;
      cmd_en = 1'b1; cmd_instr = MCB_RFSH; cmd_bl = 6'd0; cmd_byte_addr = 30'h0;
      @(negedge clk);
      cmd_instr = MCB_RD; cmd_byte_addr = 30'h100;
      @(negedge clk);
      cmd_en = 1'b0;
      // plain read would show after 3 more edges; refresh adds 8 busy cycles
      repeat (10) @(negedge clk);
      n_vec++; if (rd_empty !== 1'b1) begin n_err++; $display("FAIL rfsh_hold: rd_empty=%b want 1", rd_empty); end
      @(negedge clk);
      n_vec++; if (rd_empty !== 1'b0 || rd_data !== 32'hA0) begin
         n_err++; $display("FAIL rfsh_after: rd_empty=%b rd_data=%h want 0/000000a0", rd_empty, rd_data);
      end
      pop_word(d);
   endtask

   task automatic test_rd_stall();
      logic [31:0] d;
      send_cmd(MCB_RD, 6'd9, 30'h100);
      wait_rd_count(7'd10, "stall_fill10");
      send_cmd(MCB_RD, 6'd63, 30'h0);
      repeat (20) @(negedge clk);
      n_vec++; if (rd_count !== 7'd10) begin n_err++; $display("FAIL stall_hold10: rd_count=%0d want 10", rd_count); end
      pop_word(d);
      n_vec++; if (d !== 32'hA0) begin n_err++; $display("FAIL stall_first: got %h want 000000a0", d); end
      for (int i = 0; i < 8; i++) pop_word(d);
      repeat (10) @(negedge clk);
      n_vec++; if (rd_count !== 7'd1) begin n_err++; $display("FAIL stall_hold1: rd_count=%0d want 1", rd_count); end
      pop_word(d);
      wait_rd_count(7'd64, "stall_fill64");
      repeat (5) @(negedge clk);
      n_vec++; if (rd_count !== 7'd64 || rd_full !== 1'b1) begin
         n_err++; $display("FAIL stall_full: rd_count=%0d rd_full=%b want 64/1", rd_count, rd_full);
      end
      n_vec++; if (rd_error !== 1'b0) begin n_err++; $display("FAIL stall_no_error: rd_error=%b want 0", rd_error); end
      pop_word(d);
      n_vec++; if (d !== 32'h2222_2222) begin n_err++; $display("FAIL stall_word0: got %h want 22222222", d); end
      for (int i = 0; i < 63; i++) pop_word(d);
      n_vec++; if (rd_empty !== 1'b1) begin n_err++; $display("FAIL stall_drained: rd_empty=%b want 1", rd_empty); end
   endtask

   task automatic test_errors();
      n_vec++; if (rd_error !== 1'b0) begin n_err++; $display("FAIL err_clean: rd_error=%b want 0", rd_error); end
      send_cmd(3'b101, 6'd0, 30'h0);       // illegal instruction
      repeat (3) @(negedge clk);
      n_vec++; if (rd_error !== 1'b1) begin n_err++; $display("FAIL err_illegal: rd_error=%b want 1", rd_error); end
      apply_reset();
      n_vec++; if (rd_error !== 1'b0) begin n_err++; $display("FAIL err_rst1: rd_error=%b want 0", rd_error); end
      // commands are accepted during calibration
      for (int i = 0; i < 4; i++) send_cmd(MCB_RFSH, 6'd0, 30'h0);
      n_vec++; if (cmd_full !== 1'b1) begin n_err++; $display("FAIL err_cmd_full: cmd_full=%b want 1", cmd_full); end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (rd_error !== 1'b1) begin n_err++; $display("FAIL err_rd_sticky: rd_error=%b want 1", rd_error); end
      for (int i = 0; i < 64; i++) push_word(32'(i), 4'b0000);
      n_vec++; if (wr_full !== 1'b1 || wr_count !== 7'd64 || wr_error !== 1'b0) begin
         n_err++; $display("FAIL err_wr_fill: full=%b count=%0d err=%b want 1/64/0", wr_full, wr_count, wr_error);
      end
      push_word(32'hDEAD_BEEF, 4'b0000);
      repeat (3) @(negedge clk);
      n_vec++; if (wr_error !== 1'b1 || wr_count !== 7'd64) begin
         n_err++; $display("FAIL err_wr_over: err=%b count=%0d want 1/64", wr_error, wr_count);
      end
      apply_reset();
      n_vec++; if ({wr_error, rd_error} !== 2'b00) begin n_err++; $display("FAIL err_rst2: errors=%b want 00", {wr_error, rd_error}); end
      n_vec++; if (wr_empty !== 1'b1 || wr_count !== 7'd0 || cmd_full !== 1'b0) begin
         n_err++; $display("FAIL err_flush: wr_empty=%b wr_count=%0d cmd_full=%b want 1/0/0", wr_empty, wr_count, cmd_full);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_write_read();
      test_latency();
      test_mask();
      test_wrap();
      test_refresh();
      test_rd_stall();
      test_errors();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
